instr_dispatch: RTL

Instruction dispatch stage directly upstream of the array processor top level. It accepts 32-bit array instructions from a host/controller over a valid/ready stream and buffers them in a small FIFO. It issues them one at a time to the array, driving `instruction` stable and pulsing `start` for one cycle. It then holds off for a fixed execution budget before issuing the next instruction, so the array never sees a `start` while a previous instruction is in flight.

---
 rtl/array_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 55 +++++
 rtl/instr_dispatch.sv | 100 ++++++++++
 3 files changed

// File: rtl/array_pkg.sv
// Shared definitions for the array processor: instruction width, field positions,
// the NOP opcode and the dispatch FSM state encoding.
package array_pkg;

  localparam int ARRAY_INSTR_W = 32;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int LOW_MSB = 10;
  localparam int LOW_LSB = 0;

  localparam logic [5:0] OPC_NOP = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } dispatch_state_t;

  function automatic logic [5:0] opcode_of(input logic [ARRAY_INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; head word is visible combinationally
// so the consumer can pop and capture it in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count, so a full FIFO refuses a push
  // even in a cycle that also pops.
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_dispatch.sv
// Buffers host instructions and issues them to the array one at a time with a
// fixed execution gap. ARRAY_DISPATCH_NOP_SKIP_EN drops opcode-0 entries in IDLE.
module instr_dispatch
  import array_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int EXEC_CYCLES = 16,
  parameter int INSTR_W     = ARRAY_INSTR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     enable,
  output logic [INSTR_W-1:0]       instruction,
  output logic                     start,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              issued_count
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(EXEC_CYCLES - 1);

`ifdef ARRAY_DISPATCH_NOP_SKIP_EN
  localparam bit NOP_SKIP = 1'b1;
`else
  localparam bit NOP_SKIP = 1'b0;
`endif

  dispatch_state_t    state;
  logic [CW-1:0]      wait_cnt;
  logic [INSTR_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               head_is_nop;

  assign in_ready    = !fifo_full;
  assign pop         = (state == ST_IDLE) && enable && !fifo_empty;
  assign head_is_nop = NOP_SKIP && (opcode_of(head) == OPC_NOP);

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_instr),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // start is raised on the pop edge so it is high exactly while in ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      instruction  <= '0;
      start        <= 1'b0;
      busy         <= 1'b0;
      wait_cnt     <= '0;
      issued_count <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop && !head_is_nop) begin
            instruction <= head;
            start       <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt     <= WAIT_LOAD;
          issued_count <= issued_count + 16'd1;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
